hub75_scan_scheduler: RTL and testbench
=======================================

Name: hub75_scan_scheduler

Overview:
- Sequences one HUB75 LED matrix pixel shifter.
- Walks row banks and BCM bit planes, requesting the next row/plane shift over a start/done handshake while the current row is being displayed.
- Generates row select, latch strobe and active-low output enable, with BCM-weighted on-time scaled by a global brightness value.
- Sits between the pixel shifter (which owns data and pixel-clock generation) and the panel control pins.

Parameters:
- ROWS, 8, number of row banks; power of two.
- ROW_W, 3, width of row address (log2 ROWS).
- BITS, 12, number of BCM bit planes.
- PLANE_W, 4, width of plane index.
- BASE_TICKS, 4, display period in clk cycles of plane 0; plane p lasts BASE_TICKS<<p.
- CNT_W, 24, width of period and on-time counters; must hold BASE_TICKS<<(BITS-1).
- BLANK_CYCLES, 2, cycles with OE blanked before the strobe.
- LATCH_CYCLES, 2, strobe high duration in cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run scan; low stops at the next slot boundary.
- brightness  in  8  global on-time scale, 0..255.
- shift_start  out  1  one-cycle request to shift the next row.
- shift_row  out  ROW_W  row of the requested shift; stable from shift_start until shift_done.
- shift_plane  out  PLANE_W  plane of the requested shift; stable from shift_start until shift_done.
- shift_done  in  1  one-cycle pulse: shifter finished the shift.
- led_row  out  ROW_W  panel row select (S0..S2).
- led_stb  out  1  panel latch strobe, active high.
- led_oe_n  out  1  panel output enable, active low (1 = blanked).
- frame_start  out  1  one-cycle pulse when row 0 / plane BITS-1 is latched.

Behaviour:
- Reset values (async, immediate): led_oe_n=1, led_stb=0, led_row=0, shift_start=0, shift_row=0, shift_plane=BITS-1, frame_start=0, state IDLE. Both counters are cleared.
- Slot order:
  - Row increments every slot.
  - When row wraps from ROWS-1 to 0, plane decrements.
  - Plane 0 is followed by plane BITS-1.
- States:
  - IDLE: led_oe_n=1. When enable=1, go to SHIFT.
  - SHIFT: pulse shift_start for one cycle with the next slot's row/plane, then wait for shift_done. shift_done is ignored in the same cycle as shift_start. On shift_done, go to WAIT_DISP.
  - WAIT_DISP: hold until period_cnt==0, i.e. the previous slot's display time has expired. Then:
    - enable=0 → IDLE.
    - else → BLANK.
  - BLANK: led_oe_n forced to 1 for BLANK_CYCLES cycles. led_row is updated to the new slot row on entry. Then go to LATCH.
  - LATCH: led_stb=1 for LATCH_CYCLES cycles. On exit:
    - load period_cnt = BASE_TICKS<<plane.
    - load on_cnt = ((BASE_TICKS<<plane)*brightness)>>8, with brightness sampled at this cycle.
    - pulse frame_start if the slot is row 0 / plane BITS-1.
    - advance the slot pointer and go to SHIFT, so the next shift overlaps the display.
- Display timing:
  - From the cycle after LATCH exit, led_oe_n=0 while on_cnt>0.
  - period_cnt and on_cnt both decrement each cycle and saturate at 0.
  - led_oe_n=1 whenever on_cnt==0, in BLANK/LATCH/IDLE, or in reset.
- Shift slower than period: OE stays blanked after on_cnt expires. Latching waits for shift_done; no slot is skipped.
- brightness=0: on_cnt=0, so OE is never asserted, while timing and shifting continue normally.
- brightness changes mid-slot: they take effect at the next latch only.
- enable dropped mid-operation: the outstanding shift completes, the scheduler goes to IDLE without latching, and the slot pointer is kept. The next enable re-requests the same slot.
- Counter arithmetic: the multiply is CNT_W+8 bits wide, and the upper CNT_W bits after >>8 are used. No overflow is permitted by the parameter rules.

Test Plan:
All scenarios use ROWS=8, BITS=4, BASE_TICKS=2, BLANK_CYCLES=2, LATCH_CYCLES=2, with the bench shifter answering shift_done 3 cycles after shift_start unless stated.
- Reset, then enable=1 → first shift_start has shift_row=0, shift_plane=3. After shift_done: 2 blank cycles, 2 stb cycles, frame_start pulses once, and led_row=0.
- brightness=128, plane 3 slot → period 16 cycles; led_oe_n low exactly 8 cycles starting the cycle after stb falls.
- brightness=255, plane 0 → led_oe_n low exactly 1 cycle; brightness=0 → led_oe_n never low across a full frame of 32 slots, and frame_start pulses every 32 slots.
- shift_done delayed 40 cycles during a plane 0 slot → OE blanks after 1 cycle, led_stb stays low until shift_done plus BLANK_CYCLES, and no slot is skipped.
- Full-frame order check → rows 0..7 at plane 3, then rows 0..7 at planes 2, 1 and 0, then back to plane 3; led_oe_n never low while led_stb=1.
- reset asserted during LATCH → led_stb=0 and led_oe_n=1 immediately (same cycle, asynchronous). After release, the first request is row 0, plane 3.

Source files
------------

// File: rtl/hub75_scan_scheduler.sv
// HUB75 scan sequencer: walks rows and BCM planes, overlapping the next
// row shift with the current row's display time.
module hub75_scan_scheduler #(
    parameter int ROWS         = 8,
    parameter int ROW_W        = 3,
    parameter int BITS         = 12,
    parameter int PLANE_W      = 4,
    parameter int BASE_TICKS   = 4,
    parameter int CNT_W        = 24,
    parameter int BLANK_CYCLES = 2,
    parameter int LATCH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         brightness,
    output logic               shift_start,
    output logic [ROW_W-1:0]   shift_row,
    output logic [PLANE_W-1:0] shift_plane,
    input  logic               shift_done,
    output logic [ROW_W-1:0]   led_row,
    output logic               led_stb,
    output logic               led_oe_n,
    output logic               frame_start
);

    localparam int PH_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_REQ,
        SHIFT,
        WAIT_DISP,
        BLANK,
        LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [ROW_W-1:0]   shift_row_q, shift_row_d;
    logic [PLANE_W-1:0] shift_plane_q, shift_plane_d;
    logic [ROW_W-1:0]   led_row_q, led_row_d;
    logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]   on_cnt_q, on_cnt_d;
    logic               frame_start_q, frame_start_d;

    logic [CNT_W-1:0]   period_load;
    logic [CNT_W+7:0]   on_prod;
    logic [CNT_W-1:0]   on_load;
    logic               slot_is_first;
    logic               disp_state;

    // Full-width product keeps the >>8 exact for every plane/brightness pair.
    always_comb begin
        period_load = CNT_W'(BASE_TICKS) << shift_plane_q;
        on_prod     = {8'd0, period_load} * {{CNT_W{1'b0}}, brightness};
        on_load     = on_prod[CNT_W+7:8];
    end

    assign slot_is_first = (shift_row_q == '0) &&
                           (shift_plane_q == PLANE_W'(BITS - 1));

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        shift_row_d   = shift_row_q;
        shift_plane_d = shift_plane_q;
        led_row_d     = led_row_q;
        frame_start_d = 1'b0;
        period_cnt_d  = (period_cnt_q == '0) ? '0
                                             : period_cnt_q - CNT_W'(1);
        on_cnt_d      = (on_cnt_q == '0) ? '0 : on_cnt_q - CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT_REQ;
                end
            end
            SHIFT_REQ: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (shift_done) begin
                    state_d = WAIT_DISP;
                end
            end
            WAIT_DISP: begin
                if (period_cnt_q == '0) begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = BLANK;
                        phase_d   = '0;
                        led_row_d = shift_row_q;
                    end
                end
            end
            BLANK: begin
                if (phase_q == PH_W'(BLANK_CYCLES - 1)) begin
                    state_d = LATCH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            LATCH: begin
                if (phase_q == PH_W'(LATCH_CYCLES - 1)) begin
                    state_d       = SHIFT_REQ;
                    phase_d       = '0;
                    period_cnt_d  = period_load;
                    on_cnt_d      = on_load;
                    frame_start_d = slot_is_first;
                    if (shift_row_q == ROW_W'(ROWS - 1)) begin
                        shift_row_d   = '0;
                        shift_plane_d = (shift_plane_q == '0)
                                      ? PLANE_W'(BITS - 1)
                                      : shift_plane_q - PLANE_W'(1);
                    end else begin
                        shift_row_d = shift_row_q + ROW_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            shift_row_q   <= '0;
            shift_plane_q <= PLANE_W'(BITS - 1);
            led_row_q     <= '0;
            period_cnt_q  <= '0;
            on_cnt_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            shift_row_q   <= shift_row_d;
            shift_plane_q <= shift_plane_d;
            led_row_q     <= led_row_d;
            period_cnt_q  <= period_cnt_d;
            on_cnt_q      <= on_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Panel is lit only while a row is on display, never around the strobe.
    assign disp_state = (state_q == SHIFT_REQ) ||
                        (state_q == SHIFT) ||
                        (state_q == WAIT_DISP);

    assign shift_start = (state_q == SHIFT_REQ);
    assign shift_row   = shift_row_q;
    assign shift_plane = shift_plane_q;
    assign led_row     = led_row_q;
    assign led_stb     = (state_q == LATCH);
    assign led_oe_n    = !(disp_state && (on_cnt_q != '0));
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Randomised scoreboard bench for hub75_scan_scheduler: a slot-order and
// BCM on-time model feeds queues that a negedge monitor checks against.
module tb_hub75_scan_scheduler;

    localparam int ROWS    = 8;
    localparam int ROW_W   = 3;
    localparam int BITS    = 4;
    localparam int PLANE_W = 2;
    localparam int BASE    = 2;
    localparam int CNT_W   = 24;
    localparam int BLANK   = 2;
    localparam int LATCH   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [7:0]         brightness;
    logic               shift_start;
    logic [ROW_W-1:0]   shift_row;
    logic [PLANE_W-1:0] shift_plane;
    logic               shift_done;
    logic [ROW_W-1:0]   led_row;
    logic               led_stb;
    logic               led_oe_n;
    logic               frame_start;

    hub75_scan_scheduler #(
        .ROWS(ROWS), .ROW_W(ROW_W), .BITS(BITS), .PLANE_W(PLANE_W),
        .BASE_TICKS(BASE), .CNT_W(CNT_W),
        .BLANK_CYCLES(BLANK), .LATCH_CYCLES(LATCH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .brightness(brightness),
        .shift_start(shift_start), .shift_row(shift_row),
        .shift_plane(shift_plane), .shift_done(shift_done),
        .led_row(led_row), .led_stb(led_stb),
        .led_oe_n(led_oe_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int plane;
    } req_t;

    typedef struct {
        int row;
        int plane;
        int on;
        int period;
        bit first;
    } lat_t;

    req_t exp_req[$];
    lat_t exp_lat[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;

    // Slot n of the scan: rows count up, planes count down from the MSB.
    function automatic req_t slot_of(input int n);
        req_t s;
        s.row   = n % ROWS;
        s.plane = BITS - 1 - ((n / ROWS) % BITS);
        return s;
    endfunction

    // ---------------- monitor ----------------
    bit   prev_stb, prev_rst, busy, measuring, have_prev, have_cur;
    int   stb_len, oe_hi, on_meas, gap, frames, prev_period;
    int   rq_row, rq_plane;
    lat_t cur;
    req_t er;

    task automatic finish_on();
        measuring = 0;
        if (have_cur) begin
            n_cmp++;
            if (on_meas != cur.on) begin
                n_bad++;
                $display("FAIL on_time: row %0d plane %0d got %0d cycles, want %0d",
                         cur.row, cur.plane, on_meas, cur.on);
            end
        end
    endtask

    initial begin
        prev_stb = 0; prev_rst = 0; busy = 0; measuring = 0;
        have_prev = 0; have_cur = 0; stb_len = 0; oe_hi = 0;
        on_meas = 0; gap = 0; frames = 0; prev_period = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!prev_rst) begin
                    n_cmp++;
                    if (led_stb !== 1'b0 || led_oe_n !== 1'b1 ||
                        shift_start !== 1'b0 || frame_start !== 1'b0 ||
                        led_row !== '0 || shift_row !== '0 ||
                        shift_plane !== PLANE_W'(BITS - 1)) begin
                        n_bad++;
                        $display("FAIL reset_state: stb=%b oe_n=%b ss=%b fs=%b lrow=%0d srow=%0d splane=%0d, want 0 1 0 0 0 0 %0d",
                                 led_stb, led_oe_n, shift_start, frame_start,
                                 led_row, shift_row, shift_plane, BITS - 1);
                    end
                end
                prev_rst = 1; prev_stb = 0; busy = 0; measuring = 0;
                have_prev = 0; have_cur = 0; frames = 0; oe_hi = 0;
                gap = 0; stb_len = 0;
            end else begin
                prev_rst = 0;
                if (frame_start) frames++;
                if (shift_start) begin
                    n_cmp++;
                    if (exp_req.size() == 0) begin
                        n_bad++;
                        $display("FAIL req_unexpected: row %0d plane %0d, want none",
                                 shift_row, shift_plane);
                    end else begin
                        er = exp_req.pop_front();
                        if (shift_row !== ROW_W'(er.row) ||
                            shift_plane !== PLANE_W'(er.plane)) begin
                            n_bad++;
                            $display("FAIL req: row %0d plane %0d, want row %0d plane %0d",
                                     shift_row, shift_plane, er.row, er.plane);
                        end
                    end
                    busy = 1;
                    rq_row = int'(shift_row);
                    rq_plane = int'(shift_plane);
                end else if (shift_done && busy) begin
                    n_cmp++;
                    busy = 0;
                    if (int'(shift_row) != rq_row ||
                        int'(shift_plane) != rq_plane) begin
                        n_bad++;
                        $display("FAIL req_stable: row %0d plane %0d, want row %0d plane %0d",
                                 shift_row, shift_plane, rq_row, rq_plane);
                    end
                end
                if (led_stb) begin
                    n_cmp++;
                    if (led_oe_n !== 1'b1) begin
                        n_bad++;
                        $display("FAIL oe_during_stb: oe_n=%b, want 1", led_oe_n);
                    end
                end
                if (led_stb && !prev_stb) begin
                    if (measuring) finish_on();
                    if (have_prev) begin
                        n_cmp++;
                        if (gap < prev_period + BLANK) begin
                            n_bad++;
                            $display("FAIL period_gap: %0d cycles, want >= %0d",
                                     gap, prev_period + BLANK);
                        end
                    end
                    n_cmp++;
                    if (oe_hi < BLANK) begin
                        n_bad++;
                        $display("FAIL blank_len: %0d cycles, want >= %0d",
                                 oe_hi, BLANK);
                    end
                    n_cmp++;
                    if (exp_lat.size() == 0) begin
                        n_bad++;
                        have_cur = 0;
                        $display("FAIL latch_unexpected: led_row %0d, want no latch",
                                 led_row);
                    end else begin
                        cur = exp_lat.pop_front();
                        have_cur = 1;
                        if (led_row !== ROW_W'(cur.row)) begin
                            n_bad++;
                            $display("FAIL latch_row: led_row %0d, want %0d",
                                     led_row, cur.row);
                        end
                    end
                    stb_len = 0;
                end
                if (led_stb) stb_len++;
                if (!led_stb && prev_stb) begin
                    n_cmp++;
                    if (stb_len != LATCH) begin
                        n_bad++;
                        $display("FAIL stb_len: %0d cycles, want %0d",
                                 stb_len, LATCH);
                    end
                    gap = 0;
                    measuring = 1;
                    on_meas = 0;
                    if (have_cur) begin
                        n_cmp++;
                        if (frames != (cur.first ? 1 : 0)) begin
                            n_bad++;
                            $display("FAIL frame_start: %0d pulses, want %0d",
                                     frames, cur.first ? 1 : 0);
                        end
                        have_prev = 1;
                        prev_period = cur.period;
                    end
                    frames = 0;
                end
                if (!led_stb) gap++;
                if (measuring) begin
                    if (!led_oe_n) on_meas++;
                    else finish_on();
                end else if (!led_stb) begin
                    n_cmp++;
                    if (!led_oe_n) begin
                        n_bad++;
                        $display("FAIL oe_stray: oe_n=%b outside on-time, want 1",
                                 led_oe_n);
                    end
                end
                oe_hi = led_oe_n ? oe_hi + 1 : 0;
                prev_stb = led_stb;
            end
        end
    end

    // ---------------- stimulus / shifter model ----------------
    task automatic serve(input int delay, input int bsel, input bit drop);
        int   t;
        int   b;
        lat_t l;
        req_t s;
        t = 0;
        while (shift_start !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > 400) begin
                $display("FAIL shift_start_timeout: waited %0d cycles, want a request", t);
                $fatal(1, "no shift request");
            end
        end
        // Mid-slot brightness change must not touch the slot on display.
        brightness = 8'($urandom_range(0, 255));
        if (drop) enable = 1'b0;
        repeat (delay) @(posedge clk);
        #1;
        s = slot_of(k);
        case (bsel)
            0:       b = int'($urandom_range(0, 255));
            1:       b = 0;
            2:       b = 255;
            default: b = 128;
        endcase
        brightness = 8'(b);
        shift_done = 1'b1;
        if (!drop) begin
            l.row    = s.row;
            l.plane  = s.plane;
            l.period = BASE << s.plane;
            l.on     = (l.period * b) >> 8;
            l.first  = (s.row == 0) && (s.plane == BITS - 1);
            exp_lat.push_back(l);
            k++;
        end
        exp_req.push_back(slot_of(k));
        @(posedge clk); #1;
        shift_done = 1'b0;
        if (drop) begin
            repeat (60) @(posedge clk);
            #1;
            enable = 1'b1;
        end
    endtask

    initial begin
        int t;
        reset = 1'b1;
        enable = 1'b0;
        shift_done = 1'b0;
        brightness = 8'd0;
        k = 0;
        exp_req.push_back(slot_of(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 enable = 1'b1;

        serve(3, 3, 0);
        for (int i = 1; i < 32; i++) begin
            if (i >= 24 && i <= 26) serve((i == 26) ? 40 : 3, 2, 0);
            else serve(int'($urandom_range(1, 6)), 0, 0);
        end
        for (int i = 0; i < 32; i++) serve(int'($urandom_range(1, 4)), 1, 0);
        serve(3, 0, 1);
        serve(2, 0, 0);
        serve(5, 0, 1);
        for (int i = 0; i < 20; i++)
            serve(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), 0);

        serve(3, 0, 0);
        t = 0;
        while (led_stb !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                $display("FAIL stb_timeout: waited %0d cycles, want strobe", t);
                $fatal(1, "no strobe");
            end
        end
        #1 reset = 1'b1;
        exp_req.delete();
        exp_lat.delete();
        k = 0;
        exp_req.push_back(slot_of(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) serve(int'($urandom_range(1, 6)), 0, 0);

        repeat (80) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
